main_memory_responder: RTL
==========================

# main_memory_responder

Synchronous word-addressed main memory that services the cache's line-fill and write-back traffic. It is the responder end of the cache/memory interface: it accepts one word request at a time on `read_write_mem`/`address_mem`/`write_data_mem`, waits a programmable latency, then pulses `Done` for one cycle with `read_data_mem` valid. It sits between the cache and the testbench and replaces the ad-hoc behavioural memory models.

## Interface

Parameters:

- `LATENCY`, default 4: cycles from request capture to `Done`. Legal range is 1..15.
- `DEPTH`, default 256: number of 32-bit words. This equals the 10-bit byte address space divided by 4.

Ports:

- `clk` input, 1: the single clock. All state updates on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `req` input, 1: request valid, sampled only in IDLE. It may be tied high when paired with the cache.
- `read_write_mem` input, 1: 1 = write, 0 = read.
- `address_mem` input, 10: byte address. Word index is `address_mem[9:2]`; bits [1:0] are ignored.
- `write_data_mem` input, 32: write data.
- `Done` output, 1: one-cycle completion pulse.
- `read_data_mem` output, 32: read data. Valid while `Done`=1 and held until the next read completes.
- `busy` output, 1: high whenever the state is not IDLE.

## Operation

- Storage is `DEPTH` x 32-bit words.
  - Zero-initialised at time 0.
  - `rst` does not clear contents.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If `req`=1 at the edge, latch `read_write_mem`, `address_mem[9:2]` and `write_data_mem`.
  - Load the counter with `LATENCY`-1 and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If counter != 0, decrement it.
  - If counter == 0, perform the access and go to DONE.
    - Write: `mem[idx]` <= latched data. `read_data_mem` is unchanged.
    - Read: `read_data_mem` <= `mem[idx]`.
  - Register `Done` <= 1.
- DONE:
  - `Done` <= 0. Go to IDLE unconditionally.
  - Inputs are ignored in this state. This gives the initiator one cycle to advance its address after `posedge Done`.
- Input changes after capture (address, data, direction, `req`) have no effect on the in-flight access.
- Counter width is 4 bits.
- `LATENCY`=1 means WAIT is entered with counter 0 and completes on the next edge.
- Address wrap: index is `address_mem[9:2]` modulo `DEPTH`.
  - With the default `DEPTH` no wrap occurs.
  - With a smaller `DEPTH`, upper index bits are discarded.

## Timing

- Reset values, applied immediately on `rst`=1 regardless of clock:
  - state = IDLE, counter = 0
  - `Done`=0, `read_data_mem`=0, `busy`=0
- Request capture happens at edge E0, when IDLE and `req`=1.
  - `busy`=1 from E0.
  - At edge E0+`LATENCY`: memory access committed, `Done` rises.
  - At edge E0+`LATENCY`+1: `Done` falls, state returns to IDLE.
  - At edge E0+`LATENCY`+2: earliest next capture.
- Throughput is one word per `LATENCY`+2 cycles. A 4-word line takes 4*(`LATENCY`+2) cycles.
- `Done` is exactly one cycle wide and never asserted twice per request.
- Read-after-write to the same word, back to back, returns the new data. The write commits before the next capture is possible.
- Reset mid-operation:
  - Asserted before edge E0+`LATENCY`: the access is aborted, no write is committed and no `Done` is produced.
  - Asserted during DONE: `Done` drops immediately, but the write already committed stays.
- Simultaneous `rst` and `req` at an edge: reset wins and nothing is captured.

## Test plan

- Reset: hold `rst`=1 for 3 cycles with `req`=1 -> `Done`=0, `busy`=0, `read_data_mem`=0 throughout. First capture occurs at the first edge after `rst` falls.
- Write then read (`LATENCY`=4):
  - Write 0xDEADBEEF to 0x010, captured at E0 -> `Done` high exactly between edges E0+4 and E0+5.
  - Read 0x010 -> `read_data_mem`=0xDEADBEEF with `Done`, held after `Done` falls.
- Byte offset ignored: write 0x12345678 to 0x013, then read 0x010 -> 0x12345678.
- Cache-style burst:
  - `req` tied high; testbench adds 4 to `address_mem` on each `posedge Done`; reads start at 0x040 after preloading 0x040..0x04C with 1, 2, 3, 4.
  - Expect four `Done` pulses spaced 6 cycles apart, returning 1, 2, 3, 4 in order.
- Input change in WAIT: capture a read of 0x080 (contents 0xAAAA0000), then change `address_mem` to 0x084 and `read_write_mem` to 1 at E0+1 -> `Done` returns 0xAAAA0000 and 0x084 is unmodified.
- Reset abort: capture a write of 0xCAFEF00D to 0x0C0, assert `rst` at E0+2 for one cycle -> no `Done`, and a later read of 0x0C0 returns its prior value 0.

Source files
------------

// File: rtl/main_memory_responder_if.sv
// Cache/memory word-request bus: the initiator (cache or bench) drives the request,
// and the memory responder returns read data with a one-cycle Done pulse.
interface main_memory_responder_if;
    logic        req;
    logic        read_write_mem;
    logic [9:0]  address_mem;
    logic [31:0] write_data_mem;
    logic        Done;
    logic [31:0] read_data_mem;
    logic        busy;

    modport master (
        output req, read_write_mem, address_mem, write_data_mem,
        input  Done, read_data_mem, busy
    );

    modport slave (
        input  req, read_write_mem, address_mem, write_data_mem,
        output Done, read_data_mem, busy
    );
endinterface

// File: rtl/main_memory_responder.sv
// Word-addressed main memory with programmable access latency. It accepts one request
// at a time, completes it LATENCY cycles after capture and pulses Done for one cycle.
module main_memory_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    main_memory_responder_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        count;
    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       wdata_q;
    logic              access;

    // Contents start at zero and survive rst; only the control path is reset.
    logic [31:0] mem [DEPTH] = '{default: '0};

    assign access   = (state == WAIT) && (count == 4'd0);
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.req) state_next = WAIT;
            WAIT:    if (count == 4'd0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count             <= 4'd0;
            we_q              <= 1'b0;
            idx_q             <= '0;
            wdata_q           <= '0;
            bus.Done          <= 1'b0;
            bus.read_data_mem <= '0;
        end else begin
            bus.Done <= access;
            if (state == IDLE && bus.req) begin
                count   <= COUNT_LOAD;
                we_q    <= bus.read_write_mem;
                idx_q   <= IDX_W'(bus.address_mem[9:2]);
                wdata_q <= bus.write_data_mem;
            end else if (state == WAIT && count != 4'd0) begin
                count <= count - 4'd1;
            end
            if (access && !we_q) bus.read_data_mem <= mem[idx_q];
        end
    end

    // NOTE: the storage array has no reset so it maps onto RAM and keeps its contents across rst.
    always_ff @(posedge clk) begin
        if (access && we_q) mem[idx_q] <= wdata_q;
    end
endmodule
